// File: rtl/fpu_pkg.sv
// Shared FPU definitions.
// Holds the ROB tag width, the fixed FP adder latency and the packed
// {tag, data, exc} result entry that the CDB buffer queues.
package fpu_pkg;

    localparam int TAG_W     = 6;
    localparam int FPADD_LAT = 3;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             exc;
    } result_entry_t;

endpackage

// File: rtl/fp_result_fifo.sv
// Result FIFO for the FP add CDB buffer.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (pointers/count only)
//   clear       - empties the FIFO at the next edge (flush); wins over push/pop
//   push        - write push_data at the tail
//   push_data   - WIDTH-bit entry
//   pop         - remove the head entry
//   head_data   - current head entry, zero while empty
//   count       - number of stored entries
//   empty       - count == 0
module fp_result_fifo #(
    parameter int   DEPTH = 4,
    parameter int   WIDTH = 39,
    localparam int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Payload storage is not reset; gating on empty keeps the outputs at zero.
    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fpadd_cdb_buffer.sv
// FP add/sub issue-credit and CDB result buffer.
// Tracks ops inside the fixed-latency adder, pairs each completion with its
// ROB tag and queues results for the common data bus.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   issue_valid, issue_tag      - dispatcher offer
//   issue_ready                 - offer accepted this cycle
//   fpu_start                   - adder start (issue_valid & issue_ready)
//   fpu_done, fpu_result,
//   fpu_exception               - adder completion
//   cdb_valid, cdb_tag,
//   cdb_data, cdb_exc           - CDB request (FIFO head)
//   cdb_ready                   - CDB grant, pops the head
//   flush                       - squash queued and in-flight results
//   protocol_err                - sticky: adder completion did not match a tracked op
// TAG_W must match fpu_pkg::TAG_W, which sizes the queued entry.
module fpadd_cdb_buffer #(
    parameter int TAG_W = fpu_pkg::TAG_W,
    parameter int DEPTH = 4,
    parameter int LAT   = fpu_pkg::FPADD_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             issue_ready,
    output logic             fpu_start,
    input  logic             fpu_done,
    input  logic [31:0]      fpu_result,
    input  logic             fpu_exception,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [31:0]      cdb_data,
    output logic             cdb_exc,
    input  logic             cdb_ready,
    input  logic             flush,
    output logic             protocol_err
);

    import fpu_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IF_W  = $clog2(LAT + 1);

    logic [CNT_W-1:0]            fifo_count;
    logic                        fifo_empty;
    logic [IF_W-1:0]             in_flight;

    logic [LAT-1:0]              pipe_valid;
    logic [LAT-1:0]              pipe_killed;
    logic [LAT-1:0][TAG_W-1:0]   pipe_tag;

    // Pipeline extended by one slot: [0] is the entering op, [LAT] the op
    // leaving the head this cycle.
    logic [LAT:0]                valid_ext;
    logic [LAT:0]                killed_ext;
    logic [LAT:0][TAG_W-1:0]     tag_ext;

    logic                        head_valid;
    logic                        head_killed;
    logic [TAG_W-1:0]            head_tag;
    logic                        push;
    logic                        pop;
    result_entry_t               push_entry;
    result_entry_t               head_entry;

    assign issue_ready = rst_n & ~flush &
                         ((int'(fifo_count) + int'(in_flight)) < DEPTH);
    assign fpu_start   = issue_valid & issue_ready;

    assign valid_ext   = {pipe_valid, fpu_start};
    assign killed_ext  = {pipe_killed | ({LAT{flush}} & pipe_valid), 1'b0};
    assign tag_ext     = {pipe_tag, issue_tag};

    assign head_valid  = valid_ext[LAT];
    assign head_killed = killed_ext[LAT];
    assign head_tag    = tag_ext[LAT];

    assign push        = fpu_done & head_valid & ~head_killed & ~flush;
    assign pop         = cdb_valid & cdb_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid  <= '0;
            pipe_killed <= '0;
        end else begin
            pipe_valid  <= valid_ext[LAT-1:0];
            pipe_killed <= killed_ext[LAT-1:0];
        end
    end

    always_ff @(posedge clk) begin
        pipe_tag <= tag_ext[LAT-1:0];
    end

    // Credits are returned when the tracked op leaves the head; in normal
    // operation that is exactly the fpu_done cycle, and a stray done with no
    // tracked op cannot underflow the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= '0;
        end else begin
            case ({fpu_start, head_valid})
                2'b10:   in_flight <= in_flight + IF_W'(1);
                2'b01:   in_flight <= in_flight - IF_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            protocol_err <= 1'b0;
        end else if (fpu_done != head_valid) begin
            protocol_err <= 1'b1;
        end
    end

    always_comb begin
        push_entry      = '0;
        push_entry.tag  = head_tag;
        push_entry.data = fpu_result;
        push_entry.exc  = fpu_exception;
    end

    fp_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(result_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign cdb_valid = ~fifo_empty;
    assign cdb_tag   = head_entry.tag;
    assign cdb_data  = head_entry.data;
    assign cdb_exc   = head_entry.exc;

endmodule
